// File: rtl/spi_pkg.sv
// Shared SPI definitions: transfer geometry, baud FSM states and divisor helper.
// Used by the baud generator, shift register and controller.
package spi_pkg;

  localparam int DATA_BITS      = 8;
  localparam int HCNT_W         = 11;
  localparam int EDGES_PER_XFER = 2 * DATA_BITS;

  typedef enum logic {
    IDLE,
    RUN
  } baud_state_t;

  // Full SCLK period in PCLK cycles: (sppr+1) * 2^(spr+1).
  function automatic logic [11:0] baud_div(input logic [2:0] sppr, input logic [2:0] spr);
    logic [11:0] base;
    base = {9'd0, sppr} + 12'd1;
    return base << ({1'b0, spr} + 4'd1);
  endfunction

endpackage

// File: rtl/spi_half_period_counter.sv
// Half-period timer: counts enabled PCLK cycles and pulses tc on the last
// cycle of each half period, wrapping to zero.
module spi_half_period_counter #(
  parameter int HCNT_W = 11
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              en,
  input  logic              clr,
  input  logic [HCNT_W-1:0] h,
  output logic              tc
);

  localparam logic [HCNT_W-1:0] ONE = {{(HCNT_W-1){1'b0}}, 1'b1};

  logic [HCNT_W-1:0] hcnt;

  assign tc = en && (hcnt == (h - ONE));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      hcnt <= '0;
    end else if (clr || tc) begin
      hcnt <= '0;
    end else if (en) begin
      hcnt <= hcnt + ONE;
    end
  end

endmodule

// File: rtl/spi_baud_generator.sv
// SPI master SCLK generator: divides PCLK, drives SCLK with CPOL and emits
// shift/sample strobes on the SCLK edges selected by CPHA.
module spi_baud_generator
  import spi_pkg::*;
#(
  parameter int DATA_BITS = spi_pkg::DATA_BITS,
  parameter int HCNT_W    = spi_pkg::HCNT_W
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        start,
  input  logic        abort,
  input  logic        spi_stop,
  input  logic        cpol,
  input  logic        cpha,
  input  logic [2:0]  sppr,
  input  logic [2:0]  spr,
  output logic        sclk,
  output logic        shift_event,
  output logic        sample_event,
  output logic        busy,
  output logic        done,
  output logic [11:0] baud_divisor
);

  localparam int EDGES  = 2 * DATA_BITS;
  localparam int EDGE_W = $clog2(EDGES + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(EDGES);
  localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);
  localparam logic [HCNT_W-1:0] HCNT_ONE  = {{(HCNT_W-1){1'b0}}, 1'b1};

  baud_state_t       state;
  logic [EDGE_W-1:0] edge_cnt;
  logic [EDGE_W-1:0] edge_nxt;
  logic [HCNT_W-1:0] h_new;
  logic [HCNT_W-1:0] h_l;
  logic              cpha_l;
  logic              accept;
  logic              cnt_en;
  logic              cnt_clr;
  logic              tc;
  logic              leading;

  assign baud_divisor = baud_div(sppr, spr);
  assign h_new        = ({{(HCNT_W-3){1'b0}}, sppr} + HCNT_ONE) << spr;

  assign accept   = (state == IDLE) && start && !abort;
  // Stop counting once the final edge is out so the completion cycle is clean.
  assign cnt_en   = (state == RUN) && !spi_stop && (edge_cnt != LAST_EDGE);
  assign cnt_clr  = (state == IDLE) || abort;
  assign edge_nxt = edge_cnt + EDGE_ONE;
  assign leading  = edge_nxt[0];

  spi_half_period_counter #(
    .HCNT_W (HCNT_W)
  ) u_hcnt (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .en     (cnt_en),
    .clr    (cnt_clr),
    .h      (h_l),
    .tc     (tc)
  );

  // Transfer configuration is captured at start and ignores live changes.
  always_ff @(posedge PCLK) begin
    if (accept) begin
      h_l    <= h_new;
      cpha_l <= cpha;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state        <= IDLE;
      edge_cnt     <= '0;
      sclk         <= 1'b0;
      shift_event  <= 1'b0;
      sample_event <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      shift_event  <= 1'b0;
      sample_event <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= cpol;
          if (accept) begin
            state    <= RUN;
            busy     <= 1'b1;
            edge_cnt <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            sclk     <= cpol;
            edge_cnt <= '0;
          end else if (!spi_stop) begin
            if (edge_cnt == LAST_EDGE) begin
              state    <= IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              edge_cnt <= '0;
            end else if (tc) begin
              sclk     <= ~sclk;
              edge_cnt <= edge_nxt;
              // Odd edges lead; the first lead (CPHA=1) and last trail (CPHA=0) never shift.
              if (cpha_l) begin
                shift_event  <= leading && (edge_nxt != EDGE_ONE);
                sample_event <= !leading;
              end else begin
                sample_event <= leading;
                shift_event  <= !leading && (edge_nxt != LAST_EDGE);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
